fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory request FSM and IF/ID pipeline register.
// Handles hazard stalls, branch flushes and variable-latency memory with a one-entry hold buffer.
module fetch_stage (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        PCWrite_in,
  input  logic        IFIDWrite_in,
  input  logic        FLUSH_in,
  input  logic [31:0] Target_in,
  output logic        IMemReq_out,
  output logic [31:0] IMemAddr_out,
  input  logic        IMemAck_in,
  input  logic [31:0] IMemData_in,
  output logic [31:0] PC_out,
  output logic [31:0] IFIDInstr_out,
  output logic [31:0] IFIDPCPlus4_out,
  output logic        IFIDValid_out
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e      state_q;
  logic        req_q;
  logic [31:0] pc_q;
  logic [31:0] req_addr_q;
  logic [31:0] hold_instr_q;
  logic [31:0] hold_pc4_q;
  logic [31:0] ifid_instr_q;
  logic [31:0] ifid_pc4_q;
  logic        ifid_valid_q;

  logic        advance;
  logic [31:0] req_pc4;
  logic [31:0] flush_pc;

  assign advance  = PCWrite_in & IFIDWrite_in;
  assign req_pc4  = req_addr_q + 32'd4;
  // PC value after a flush: redirected only if the hazard unit lets the PC move.
  assign flush_pc = PCWrite_in ? Target_in : pc_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      pc_q         <= '0;
      req_addr_q   <= '0;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q    <= StFetch;
          req_q      <= 1'b1;
          req_addr_q <= pc_q;
        end

        StFetch: begin
          if (FLUSH_in) begin
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            pc_q         <= flush_pc;
            if (IMemAck_in) begin
              req_addr_q <= flush_pc;
            end else begin
              // Outstanding request must complete at its original address.
              state_q <= StDrain;
            end
          end else if (IMemAck_in) begin
            if (advance) begin
              ifid_instr_q <= IMemData_in;
              ifid_pc4_q   <= req_pc4;
              ifid_valid_q <= 1'b1;
              pc_q         <= req_pc4;
              req_addr_q   <= req_pc4;
            end else begin
              hold_instr_q <= IMemData_in;
              hold_pc4_q   <= req_pc4;
              state_q      <= StHold;
              req_q        <= 1'b0;
            end
          end else if (IFIDWrite_in) begin
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
          end
        end

        StHold: begin
          if (FLUSH_in) begin
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            pc_q         <= flush_pc;
            req_addr_q   <= flush_pc;
            state_q      <= StFetch;
            req_q        <= 1'b1;
          end else if (advance) begin
            ifid_instr_q <= hold_instr_q;
            ifid_pc4_q   <= hold_pc4_q;
            ifid_valid_q <= 1'b1;
            pc_q         <= hold_pc4_q;
            req_addr_q   <= hold_pc4_q;
            state_q      <= StFetch;
            req_q        <= 1'b1;
          end
        end

        StDrain: begin
          if (FLUSH_in) begin
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            pc_q         <= flush_pc;
          end else if (IFIDWrite_in) begin
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
          end
          if (IMemAck_in) begin
            req_addr_q <= FLUSH_in ? flush_pc : pc_q;
            state_q    <= StFetch;
          end
        end

        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign IMemReq_out     = req_q;
  assign IMemAddr_out    = req_addr_q;
  assign PC_out          = pc_q;
  assign IFIDInstr_out   = ifid_instr_q;
  assign IFIDPCPlus4_out = ifid_pc4_q;
  assign IFIDValid_out   = ifid_valid_q;

endmodule
